// File: rtl/revo_frame9_tracker.sv
// revo_frame9_tracker: locks a flywheel bunch/revolution counter to the decoded revo marker
// and produces frame/frame9 strobes, a lock flag and a saturating error tally.
module revo_frame9_tracker #(
    parameter int REVOLUTION_CLOCKS = 1280,
    parameter int FRAMES_PER_FRAME9 = 9,
    parameter int LOCK_COUNT        = 4,
    parameter int MISS_TOLERANCE    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        revo_in,
    input  logic        clear_errors,
    output logic [10:0] bunch_count,
    output logic [3:0]  revolution_index,
    output logic        frame,
    output logic        frame9,
    output logic        locked,
    output logic [7:0]  error_count
);
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
    state_t state, state_n;
    logic revo_prev, rise, w, aligned, misaligned, load, err_inc, rev_bad, rev_bad_n;
    logic [7:0] good, good_n, bad, bad_n;
    logic [10:0] bc_n;
    logic [3:0] ri_n;
    always_comb begin
        rise       = revo_in & ~revo_prev;
        w          = bunch_count == 11'(REVOLUTION_CLOCKS - 1);
        aligned    = rise & w;
        misaligned = rise & ~w;
        state_n    = state;
        good_n     = good;
        bad_n      = bad;
        rev_bad_n  = 1'b0;
        load       = 1'b0;
        err_inc    = 1'b0;
        case (state)
            HUNT: if (rise) begin
                load    = 1'b1;
                good_n  = 8'd1;
                state_n = VERIFY;
            end
            VERIFY: if (aligned) begin
                good_n = good + 8'd1;
                if (good_n == 8'(LOCK_COUNT)) begin
                    state_n = LOCKED;
                    bad_n   = 8'd0;
                end
            end else if (misaligned) begin
                err_inc = 1'b1;
                load    = 1'b1;
                good_n  = 8'd1;
            end else if (w) begin
                err_inc = 1'b1;
                good_n  = 8'd0;
                state_n = HUNT;
            end
            LOCKED: begin
                // flywheel: misaligned edges only taint the revolution, never realign
                err_inc   = misaligned | (w & ~rise);
                rev_bad_n = rev_bad | misaligned;
                if (w) begin
                    rev_bad_n = 1'b0;
                    if (rev_bad | ~rise) begin
                        bad_n = bad + 8'd1;
                        if (bad_n == 8'(MISS_TOLERANCE)) begin
                            state_n = HUNT;
                            good_n  = 8'd0;
                        end
                    end else begin
                        bad_n = 8'd0;
                    end
                end
            end
            default: state_n = HUNT;
        endcase
        bc_n = (load | w) ? 11'd0 : bunch_count + 11'd1;
        ri_n = load ? 4'd0 :
               w ? (revolution_index == 4'(FRAMES_PER_FRAME9 - 1) ? 4'd0 : revolution_index + 4'd1) :
               revolution_index;
    end
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= HUNT;
            revo_prev        <= 1'b0;
            good             <= 8'd0;
            bad              <= 8'd0;
            rev_bad          <= 1'b0;
            bunch_count      <= 11'd0;
            revolution_index <= 4'd0;
            frame            <= 1'b0;
            frame9           <= 1'b0;
            error_count      <= 8'd0;
        end else begin
            state            <= state_n;
            revo_prev        <= revo_in;
            good             <= good_n;
            bad              <= bad_n;
            rev_bad          <= rev_bad_n;
            bunch_count      <= bc_n;
            revolution_index <= ri_n;
            frame            <= (state_n == LOCKED) && (bc_n == 11'd0);
            frame9           <= (state_n == LOCKED) && (bc_n == 11'd0) && (ri_n == 4'd0);
            error_count      <= clear_errors ? 8'd0 :
                                (err_inc && error_count != 8'hff) ? error_count + 8'd1 : error_count;
        end
    end
    assign locked = state == LOCKED;
endmodule

// File: tb/tb_revo_frame9_tracker.sv
// tb_revo_frame9_tracker: randomized revo patterns checked every cycle against a phase-origin
// reference model, plus directed lock, saturation and async-reset checks.
module tb_revo_frame9_tracker;
    localparam int RC = 20, NF = 3, LC = 4, MT = 2;
    logic clock = 1'b0, reset_n = 1'b0, revo_in = 1'b0, clear_errors = 1'b0;
    logic [10:0] bunch_count;
    logic [3:0]  revolution_index;
    logic        frame, frame9, locked;
    logic [7:0]  error_count;
    int n_total = 0, n_bad = 0;
    int cyc, t0, mode, good, m_bad, err, last_mis, rise_at;
    bit mprev, en_rclr, seen;

    revo_frame9_tracker #(.REVOLUTION_CLOCKS(RC), .FRAMES_PER_FRAME9(NF),
                          .LOCK_COUNT(LC), .MISS_TOLERANCE(MT)) dut (
        .clock(clock), .reset_n(reset_n), .revo_in(revo_in), .clear_errors(clear_errors),
        .bunch_count(bunch_count), .revolution_index(revolution_index), .frame(frame),
        .frame9(frame9), .locked(locked), .error_count(error_count));

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        cyc = 0; t0 = 0; mode = 0; good = 0; m_bad = 0; err = 0; last_mis = -1; mprev = 1'b0;
    endtask

    // Phase is kept as the cycle t0 where bunch 0 last started; positions follow by arithmetic.
    task automatic model(input bit r, input bit c);
        int pos;
        bit wrap, rise, ld, inc;
        pos = (cyc - t0) % RC;
        wrap = pos == RC - 1;
        rise = r && !mprev;
        ld = 1'b0;
        inc = 1'b0;
        mprev = r;
        if (mode == 0) begin
            if (rise) begin ld = 1'b1; good = 1; mode = 1; end
        end else if (mode == 1) begin
            if (rise && wrap) begin
                good++;
                if (good == LC) begin mode = 2; m_bad = 0; end
            end else if (rise) begin inc = 1'b1; ld = 1'b1; good = 1; end
            else if (wrap) begin inc = 1'b1; good = 0; mode = 0; end
        end else begin
            if (rise && !wrap) begin inc = 1'b1; last_mis = cyc; end
            if (wrap) begin
                if (!rise) inc = 1'b1;
                if (!rise || last_mis >= cyc - pos) begin
                    m_bad++;
                    if (m_bad == MT) begin mode = 0; good = 0; end
                end else m_bad = 0;
            end
        end
        err = c ? 0 : (inc && err < 255) ? err + 1 : err;
        cyc++;
        if (ld) t0 = cyc;
    endtask

    task automatic step(input bit r, input bit c);
        int b, ri;
        revo_in = r;
        clear_errors = c;
        @(posedge clock);
        model(r, c);
        @(negedge clock);
        b = (cyc - t0) % RC;
        ri = ((cyc - t0) / RC) % NF;
        check("bunch_count", int'(bunch_count), b);
        check("revolution_index", int'(revolution_index), ri);
        check("locked", int'(locked), int'(mode == 2));
        check("frame", int'(frame), int'(mode == 2 && b == 0));
        check("frame9", int'(frame9), int'(mode == 2 && b == 0 && ri == 0));
        check("error_count", int'(error_count), err);
        if (locked && !seen) begin seen = 1'b1; rise_at = cyc; end
    endtask

    function automatic bit rclr();
        return en_rclr && ($urandom_range(0, 63) == 0);
    endfunction

    task automatic rev(input int pos, input int len);
        for (int i = 0; i < RC; i++) step(pos >= 0 && i >= pos && i < pos + len, rclr());
    endtask

    task automatic async_reset();
        @(posedge clock);
        #2 reset_n = 1'b0; revo_in = 1'b0; clear_errors = 1'b0;
        #1;
        check("rst_bunch", int'(bunch_count), 0);
        check("rst_rev", int'(revolution_index), 0);
        check("rst_frame", int'(frame), 0);
        check("rst_frame9", int'(frame9), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_err", int'(error_count), 0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        en_rclr = 1'b0; seen = 1'b0; rise_at = -1;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        // clean lock: pulses at cycles 10, 30, 50, 70
        repeat (10) step(1'b0, 1'b0);
        repeat (8) rev(0, 1);
        check("lock_rise_cycle", rise_at, 71);
        check("clean_err", int'(error_count), 0);
        // one revo one clock late
        rev(1, 1);
        check("jitter_err", int'(error_count), 2);
        repeat (6) rev(0, 1);
        // randomized revolutions with occasional clears
        en_rclr = 1'b1;
        repeat (60) begin
            case ($urandom_range(0, 5))
                0, 1: rev(0, 1);
                2: rev(-1, 0);
                3: rev($urandom_range(1, RC - 1), 1);
                4: rev(0, $urandom_range(2, RC));
                default: rev($urandom_range(0, RC - 1), $urandom_range(1, 4));
            endcase
        end
        en_rclr = 1'b0;
        // loss of revo after lock
        repeat (6) rev(0, 1);
        check("pre_loss_locked", int'(locked), 1);
        repeat (3) rev(-1, 0);
        check("loss_unlocked", int'(locked), 0);
        // phase step of +5 after lock
        repeat (6) rev(0, 1);
        repeat (8) rev(5, 1);
        check("phase_step_relocked", int'(locked), 1);
        // saturation: a stream of misaligned edges in VERIFY
        async_reset();
        repeat (302) begin step(1'b1, 1'b0); step(1'b0, 1'b0); end
        check("saturated", int'(error_count), 255);
        step(1'b1, 1'b1);
        check("clear_wins", int'(error_count), 0);
        // async reset while locked, then re-lock
        async_reset();
        repeat (3) step(1'b0, 1'b0);
        repeat (6) rev(0, 1);
        check("pre_reset_locked", int'(locked), 1);
        async_reset();
        repeat (4) step(1'b0, 1'b0);
        repeat (5) rev(0, 1);
        check("relocked_after_reset", int'(locked), 1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
